vars_base: RTL and testbench
============================

Name: vars_base

Overview:
- Variable-state store for one bin of the SAT engine; the counterpart of the decision unit.
- Holds value, implied flag and decision level for every bin variable, and drives the per-variable state vector to the decision unit.
- Sequences decision requests, absorbs implication writes from propagation, and performs level-based backtrack.
- Reports the backtrack level back to the decision unit.

Parameters:
- NUM_BIN_VARS, 24, variables held per bin.
- LEVEL_WIDTH, 16, decision-level width; must match the decision unit's level bus.
- IDX_WIDTH, 5, variable index width; ceil(log2(NUM_BIN_VARS)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- run_i  in  1  start-search pulse, accepted in IDLE/SAT/UNSAT only.
- start_decision_o  out  1  one-cycle decision request.
- vars_value_o  out  NUM_BIN_VARS*3  per-var state; var k at [3k+2:3k].
- vars_decided_i  in  NUM_BIN_VARS  decision result; the chosen var is the single 0 bit; all-ones means no unassigned var.
- decision_done_i  in  1  vars_decided_i valid this cycle.
- cur_level_i  in  LEVEL_WIDTH  current level from the decision unit.
- imply_valid_i  in  1  implication write strobe.
- imply_idx_i  in  IDX_WIDTH  implied variable index.
- imply_value_i  in  1  implied value, 1 = true.
- imply_done_i  in  1  propagation finished without conflict.
- conflict_i  in  1  propagation conflict.
- bkt_target_i  in  LEVEL_WIDTH  backtrack target level, sampled with conflict_i.
- bkt_level_o  out  LEVEL_WIDTH  backtrack level to the decision unit.
- bkt_level_valid_o  out  1  one-cycle strobe for bkt_level_o.
- sat_o  out  1  held high in SAT.
- unsat_o  out  1  held high in UNSAT.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-low. While rst = 0:
  - every var state is 3'b000 and every var level is 0;
  - state is IDLE;
  - all outputs are 0.
- Var encoding: bits[2:1] hold the value: 00 unassigned, 01 false, 10 true; 11 is never written. bit0 = 1 means implied, 0 means decided. vars_value_o is registered straight from the state regs.
- FSM states: IDLE, REQ, WAIT_DEC, PROP, BKT, SAT, UNSAT.
- IDLE: on run_i, clear all vars and levels, then go to REQ.
- REQ: start_decision_o = 1 for exactly one cycle, then go to WAIT_DEC.
- WAIT_DEC, on decision_done_i:
  - vars_decided_i all ones: go to SAT; sat_o = 1 from the next cycle.
  - Exactly one zero bit at index k: var k <= 3'b100 (true, decided), level[k] <= cur_level_i; go to PROP.
  - More than one zero bit: the lowest index wins.
- PROP, on imply_valid_i:
  - Target var unassigned: var <= {imply_value_i ? 2'b10 : 2'b01, 1'b1}, level <= cur_level_i.
  - Target var assigned: the write is ignored.
  - imply_idx_i >= NUM_BIN_VARS: the write is ignored.
- PROP exits:
  - imply_done_i: go to REQ.
  - conflict_i: go to BKT if cur_level_i != 0, otherwise go to UNSAT.
  - conflict_i wins over imply_done_i when both are high.
  - An imply_valid_i in the same cycle as conflict_i is still applied.
- BKT (one cycle):
  - Every var with level > target: state <= 000, level <= 0. target is bkt_target_i registered on conflict entry.
  - bkt_level_o <= target and bkt_level_valid_o = 1 for exactly this one cycle.
  - Next state is REQ.
  - A target >= cur_level_i clears nothing, but the strobe still fires.
- SAT / UNSAT: var state is frozen; the flag stays high until run_i, which clears the flag and restarts as in IDLE.
- Ignored inputs: run_i outside IDLE/SAT/UNSAT, and decision_done_i outside WAIT_DEC.
- Reset mid-operation: immediate return to IDLE with all state cleared. No request or strobe is emitted on reset release.
- Latency:
  - run_i to start_decision_o: 1 cycle.
  - decision_done_i to var update visible on vars_value_o: 1 cycle.
  - conflict_i to bkt_level_valid_o: 1 cycle.

Test Plan:
- Reset: rst low mid-PROP with vars assigned -> all vars_value_o = 0, all outputs 0, state IDLE; no start_decision_o after release until run_i.
- Decision: run_i; decision returns vars_decided_i = 24'hFFFFFB, cur_level_i = 1 -> vars_value_o[8:6] = 3'b100, level[2] = 1, FSM in PROP.
- Implication filter:
  - imply idx 5 value 0 -> var5 = 3'b011.
  - Repeat idx 5 value 1 -> unchanged.
  - idx 30 -> ignored.
- Backtrack:
  - Setup: vars at levels 1, 2, 3; cur_level_i = 3.
  - Stimulus: conflict_i with bkt_target_i = 1.
  - Response: level-2 and level-3 vars become 000; level-1 var is kept; bkt_level_valid_o pulses once with bkt_level_o = 1; then start_decision_o.
- Terminal states:
  - vars_decided_i = 24'hFFFFFF -> sat_o = 1 and held.
  - conflict_i at cur_level_i = 0 -> unsat_o = 1.
  - run_i in either state clears the flag and restarts.
- Simultaneous events: imply_done_i and conflict_i in the same cycle -> BKT path taken.

Source files
------------

// File: rtl/vars_base_if.sv
// Handshake bundle between the variable store of one bin and its decision/propagation partners.
// The slave view belongs to vars_base; the master view drives it.
interface vars_base_if #(
  parameter int NUM_BIN_VARS = 24,
  parameter int LEVEL_WIDTH  = 16,
  parameter int IDX_WIDTH    = 5
);
  logic                      run_i;
  logic                      start_decision_o;
  logic [NUM_BIN_VARS*3-1:0] vars_value_o;
  logic [NUM_BIN_VARS-1:0]   vars_decided_i;
  logic                      decision_done_i;
  logic [LEVEL_WIDTH-1:0]    cur_level_i;
  logic                      imply_valid_i;
  logic [IDX_WIDTH-1:0]      imply_idx_i;
  logic                      imply_value_i;
  logic                      imply_done_i;
  logic                      conflict_i;
  logic [LEVEL_WIDTH-1:0]    bkt_target_i;
  logic [LEVEL_WIDTH-1:0]    bkt_level_o;
  logic                      bkt_level_valid_o;
  logic                      sat_o;
  logic                      unsat_o;

  modport slave (
    input  run_i, vars_decided_i, decision_done_i, cur_level_i,
           imply_valid_i, imply_idx_i, imply_value_i, imply_done_i,
           conflict_i, bkt_target_i,
    output start_decision_o, vars_value_o, bkt_level_o, bkt_level_valid_o,
           sat_o, unsat_o
  );

  modport master (
    output run_i, vars_decided_i, decision_done_i, cur_level_i,
           imply_valid_i, imply_idx_i, imply_value_i, imply_done_i,
           conflict_i, bkt_target_i,
    input  start_decision_o, vars_value_o, bkt_level_o, bkt_level_valid_o,
           sat_o, unsat_o
  );
endinterface

// File: rtl/vars_base.sv
// Variable-state store for one SAT bin: value/implied/level per variable, decision
// sequencing, implication absorption and level-based backtrack.
module vars_base #(
  parameter int NUM_BIN_VARS = 24,
  parameter int LEVEL_WIDTH  = 16,
  parameter int IDX_WIDTH    = 5
) (
  input  logic         clk,
  input  logic         rst,
  vars_base_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DEC, S_PROP, S_BKT, S_SAT, S_UNSAT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             r_var   [NUM_BIN_VARS];
  logic [LEVEL_WIDTH-1:0] r_level [NUM_BIN_VARS];
  logic [LEVEL_WIDTH-1:0] r_target;

  logic                   w_start;
  logic                   w_bkt_valid;
  logic                   w_clear_all;
  logic                   w_dec_hit;
  logic [IDX_WIDTH-1:0]   w_dec_idx;
  logic                   w_imply_ok;
  logic [NUM_BIN_VARS*3-1:0] w_vars;

  // Lowest-index zero in the decision vector; no hit means every var is assigned.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int k = NUM_BIN_VARS - 1; k >= 0; k--) begin
      if (!bus.vars_decided_i[k]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = IDX_WIDTH'(k);
      end
    end
  end

  always_comb begin
    w_imply_ok = 1'b0;
    if (bus.imply_valid_i && (int'(bus.imply_idx_i) < NUM_BIN_VARS))
      w_imply_ok = (r_var[bus.imply_idx_i][2:1] == 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_bkt_valid = 1'b0;
    w_clear_all = 1'b0;
    case (r_state)
      S_IDLE, S_SAT, S_UNSAT: begin
        if (bus.run_i) begin
          w_clear_all = 1'b1;
          w_next      = S_REQ;
        end
      end
      S_REQ: begin
        w_start = 1'b1;
        w_next  = S_WAIT_DEC;
      end
      S_WAIT_DEC: begin
        if (bus.decision_done_i)
          w_next = w_dec_hit ? S_PROP : S_SAT;
      end
      S_PROP: begin
        // A conflict takes priority over a simultaneous imply_done.
        if (bus.conflict_i)
          w_next = (bus.cur_level_i != '0) ? S_BKT : S_UNSAT;
        else if (bus.imply_done_i)
          w_next = S_REQ;
      end
      S_BKT: begin
        w_bkt_valid = 1'b1;
        w_next      = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the var/level arrays are reset explicitly because reset must leave every var unassigned.
      for (int k = 0; k < NUM_BIN_VARS; k++) begin
        r_var[k]   <= '0;
        r_level[k] <= '0;
      end
      r_target <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_SAT, S_UNSAT: begin
          if (w_clear_all) begin
            for (int k = 0; k < NUM_BIN_VARS; k++) begin
              r_var[k]   <= '0;
              r_level[k] <= '0;
            end
          end
        end
        S_WAIT_DEC: begin
          if (bus.decision_done_i && w_dec_hit) begin
            r_var[w_dec_idx]   <= 3'b100;
            r_level[w_dec_idx] <= bus.cur_level_i;
          end
        end
        S_PROP: begin
          if (w_imply_ok) begin
            r_var[bus.imply_idx_i]   <= {(bus.imply_value_i ? 2'b10 : 2'b01), 1'b1};
            r_level[bus.imply_idx_i] <= bus.cur_level_i;
          end
          if (bus.conflict_i)
            r_target <= bus.bkt_target_i;
        end
        S_BKT: begin
          for (int k = 0; k < NUM_BIN_VARS; k++) begin
            if (r_level[k] > r_target) begin
              r_var[k]   <= '0;
              r_level[k] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_vars = '0;
    for (int k = 0; k < NUM_BIN_VARS; k++)
      w_vars[3*k +: 3] = r_var[k];
  end

  assign bus.vars_value_o      = w_vars;
  assign bus.start_decision_o  = w_start;
  assign bus.bkt_level_valid_o = w_bkt_valid;
  assign bus.bkt_level_o       = r_target;
  assign bus.sat_o             = (r_state == S_SAT);
  assign bus.unsat_o           = (r_state == S_UNSAT);

endmodule

// File: tb/tb_vars_base.sv
// Directed, table-driven bench for vars_base: one table row per clock cycle,
// followed by a hand-written reset-mid-propagation sequence.
module tb_vars_base;

  localparam int NV = 24;
  localparam int LW = 16;
  localparam int IW = 5;

  logic clk;
  logic rst;

  vars_base_if #(.NUM_BIN_VARS(NV), .LEVEL_WIDTH(LW), .IDX_WIDTH(IW)) bus ();

  vars_base #(.NUM_BIN_VARS(NV), .LEVEL_WIDTH(LW), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          run;
    logic          dd;
    logic [NV-1:0] dec;
    logic [LW-1:0] lvl;
    logic          iv;
    logic [IW-1:0] idx;
    logic          ival;
    logic          idone;
    logic          conf;
    logic [LW-1:0] tgt;
    logic          e_start;
    logic [71:0]   e_vars;
    logic          e_bv;
    logic [LW-1:0] e_bl;
    logic          e_sat;
    logic          e_unsat;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic run, input logic dd, input logic [NV-1:0] dec, input logic [LW-1:0] lvl,
    input logic iv, input logic [IW-1:0] idx, input logic ival, input logic idone,
    input logic conf, input logic [LW-1:0] tgt,
    input logic e_start, input logic [71:0] e_vars, input logic e_bv,
    input logic [LW-1:0] e_bl, input logic e_sat, input logic e_unsat);
    vec_t v;
    v.run = run; v.dd = dd; v.dec = dec; v.lvl = lvl; v.iv = iv; v.idx = idx;
    v.ival = ival; v.idone = idone; v.conf = conf; v.tgt = tgt;
    v.e_start = e_start; v.e_vars = e_vars; v.e_bv = e_bv; v.e_bl = e_bl;
    v.e_sat = e_sat; v.e_unsat = e_unsat;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.run_i           = 1'b0;
    bus.decision_done_i = 1'b0;
    bus.vars_decided_i  = '1;
    bus.cur_level_i     = '0;
    bus.imply_valid_i   = 1'b0;
    bus.imply_idx_i     = '0;
    bus.imply_value_i   = 1'b0;
    bus.imply_done_i    = 1'b0;
    bus.conflict_i      = 1'b0;
    bus.bkt_target_i    = '0;
  endtask

  task automatic check_outputs(input string tag, input logic e_start, input logic [71:0] e_vars,
                               input logic e_bv, input logic e_sat, input logic e_unsat);
    check({tag, ".start"}, 72'(bus.start_decision_o), 72'(e_start));
    check({tag, ".vars"},  72'(bus.vars_value_o),     e_vars);
    check({tag, ".bkt_v"}, 72'(bus.bkt_level_valid_o), 72'(e_bv));
    check({tag, ".sat"},   72'(bus.sat_o),            72'(e_sat));
    check({tag, ".unsat"}, 72'(bus.unsat_o),          72'(e_unsat));
  endtask

  initial begin
    //            run dd dec        lvl iv idx ival idone conf tgt  start vars             bv bl sat unsat
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   0, 72'h0,            0, 0, 0, 0)); // 0 idle, no request
    vecs.push_back(mk(1, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   1, 72'h0,            0, 0, 0, 0)); // 1 run -> REQ
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   0, 72'h0,            0, 0, 0, 0)); // 2 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFFFB, 1, 0, 0,  0,   0,    0,  0,   0, 72'h100,          0, 0, 0, 0)); // 3 var2 decided L1
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 1, 5,  0,   0,    0,  0,   0, 72'h18100,        0, 0, 0, 0)); // 4 imply var5 false
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 1, 5,  1,   0,    0,  0,   0, 72'h18100,        0, 0, 0, 0)); // 5 repeat var5 ignored
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 1, 30, 1,   0,    0,  0,   0, 72'h18100,        0, 0, 0, 0)); // 6 idx 30 ignored
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 0, 0,  0,   1,    0,  0,   1, 72'h18100,        0, 0, 0, 0)); // 7 imply_done -> REQ
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 0, 0,  0,   0,    0,  0,   0, 72'h18100,        0, 0, 0, 0)); // 8 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFF0F, 2, 0, 0,  0,   0,    0,  0,   0, 72'h1C100,        0, 0, 0, 0)); // 9 lowest zero (var4) L2
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 2, 1, 0,  1,   0,    0,  0,   0, 72'h1C105,        0, 0, 0, 0)); // 10 imply var0 true L2
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 2, 0, 0,  0,   1,    0,  0,   1, 72'h1C105,        0, 0, 0, 0)); // 11 -> REQ
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 2, 0, 0,  0,   0,    0,  0,   0, 72'h1C105,        0, 0, 0, 0)); // 12 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFF7F, 3, 0, 0,  0,   0,    0,  0,   0, 72'h81C105,       0, 0, 0, 0)); // 13 var7 decided L3
    vecs.push_back(mk(1, 0, 24'hFFFFFF, 3, 1, 9,  0,   0,    0,  0,   0, 72'h1881C105,     0, 0, 0, 0)); // 14 imply var9, run ignored
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 3, 1, 10, 1,   1,    1,  1,   0, 72'h15881C105,    1, 1, 0, 0)); // 15 conflict+done+imply
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 3, 0, 0,  0,   0,    0,  0,   1, 72'h18100,        0, 0, 0, 0)); // 16 levels >1 cleared
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 0, 0,  0,   0,    0,  0,   0, 72'h18100,        0, 0, 0, 0)); // 17 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFFFF, 1, 0, 0,  0,   0,    0,  0,   0, 72'h18100,        0, 0, 1, 0)); // 18 all ones -> SAT
    vecs.push_back(mk(0, 1, 24'hFFFFFE, 1, 0, 0,  0,   0,    0,  0,   0, 72'h18100,        0, 0, 1, 0)); // 19 SAT held, decision ignored
    vecs.push_back(mk(1, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   1, 72'h0,            0, 0, 0, 0)); // 20 run from SAT
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   0, 72'h0,            0, 0, 0, 0)); // 21 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFFFE, 1, 0, 0,  0,   0,    0,  0,   0, 72'h4,            0, 0, 0, 0)); // 22 var0 decided L1
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    1,  0,   0, 72'h4,            0, 0, 0, 1)); // 23 conflict at L0 -> UNSAT
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 1, 1,  1,   0,    0,  0,   0, 72'h4,            0, 0, 0, 1)); // 24 UNSAT frozen
    vecs.push_back(mk(1, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   1, 72'h0,            0, 0, 0, 0)); // 25 run from UNSAT
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 0, 0, 0,  0,   0,    0,  0,   0, 72'h0,            0, 0, 0, 0)); // 26 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFFFD, 1, 0, 0,  0,   0,    0,  0,   0, 72'h20,           0, 0, 0, 0)); // 27 var1 decided L1
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 0, 0,  0,   0,    1,  1,   0, 72'h20,           1, 1, 0, 0)); // 28 target == cur level
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 0, 0,  0,   0,    0,  0,   1, 72'h20,           0, 0, 0, 0)); // 29 nothing cleared
    vecs.push_back(mk(0, 0, 24'hFFFFFF, 1, 0, 0,  0,   0,    0,  0,   0, 72'h20,           0, 0, 0, 0)); // 30 WAIT_DEC
    vecs.push_back(mk(0, 1, 24'hFFFFFC, 2, 0, 0,  0,   0,    0,  0,   0, 72'h24,           0, 0, 0, 0)); // 31 var0 decided -> PROP

    idle_inputs();
    rst = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 72'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.run_i           = vecs[i].run;
      bus.decision_done_i = vecs[i].dd;
      bus.vars_decided_i  = vecs[i].dec;
      bus.cur_level_i     = vecs[i].lvl;
      bus.imply_valid_i   = vecs[i].iv;
      bus.imply_idx_i     = vecs[i].idx;
      bus.imply_value_i   = vecs[i].ival;
      bus.imply_done_i    = vecs[i].idone;
      bus.conflict_i      = vecs[i].conf;
      bus.bkt_target_i    = vecs[i].tgt;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_vars,
                    vecs[i].e_bv, vecs[i].e_sat, vecs[i].e_unsat);
      if (vecs[i].e_bv)
        check($sformatf("vec%0d.bkt_level", i), 72'(bus.bkt_level_o), 72'(vecs[i].e_bl));
    end

    // Reset asserted while in PROP with vars assigned: clears asynchronously.
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    check_outputs("rst_mid", 1'b0, 72'h0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.bkt_level", 72'(bus.bkt_level_o), 72'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_rst%0d", c), 1'b0, 72'h0, 1'b0, 1'b0, 1'b0);
    end

    // run_i after reset: one-cycle request, then a decision lands at level 1.
    @(negedge clk);
    bus.run_i = 1'b1;
    @(posedge clk);
    #1;
    check("restart.start", 72'(bus.start_decision_o), 72'h1);
    @(negedge clk);
    bus.run_i = 1'b0;
    @(posedge clk);
    #1;
    check("restart.start_drop", 72'(bus.start_decision_o), 72'h0);
    @(negedge clk);
    bus.decision_done_i = 1'b1;
    bus.vars_decided_i  = 24'hFFFFFB;
    bus.cur_level_i     = 16'd1;
    @(posedge clk);
    #1;
    check("restart.vars", 72'(bus.vars_value_o), 72'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
